// File: rtl/tt_um_2bits_alu.sv
// Registered 4-bit ALU with C/Z/N/V flags and a seven-segment display of the result.
// Operands come from ui_in and the opcode from uio_in[2:0]. Outputs are decoded only from registers.
module tt_um_2bits_alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_t;

    logic [3:0] op_a;
    logic [3:0] op_b;
    opcode_t    opcode;

    logic [4:0] sum_wide;
    logic [4:0] diff_wide;

    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;

    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;

    logic [6:0] segments;

    // The rst_n name is inherited from the pin list; it is active-high here.
    logic unused_inputs;

    assign op_a   = ui_in[3:0];
    assign op_b   = ui_in[7:4];
    assign opcode = opcode_t'(uio_in[2:0]);
    assign unused_inputs = &{1'b0, uio_in[7:3]};

    assign sum_wide  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_wide = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_result   = 4'h0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result   = sum_wide[3:0];
                alu_carry    = sum_wide[4];
                alu_overflow = (op_a[3] == op_b[3]) && (sum_wide[3] != op_a[3]);
            end
            OP_SUB: begin
                // Bit 4 of the widened difference is set exactly when A < B.
                alu_result   = diff_wide[3:0];
                alu_carry    = diff_wide[4];
                alu_overflow = (op_a[3] != op_b[3]) && (diff_wide[3] != op_a[3]);
            end
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_XOR: alu_result = op_a ^ op_b;
            OP_NOT: alu_result = ~op_a;
            OP_SHL: begin
                alu_result = {op_a[2:0], 1'b0};
                alu_carry  = op_a[3];
            end
            OP_SHR: begin
                alu_result = {1'b0, op_a[3:1]};
                alu_carry  = op_a[0];
            end
            default: alu_result = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            result   <= 4'h0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (ena) begin
            result   <= alu_result;
            carry    <= alu_carry;
            zero     <= (alu_result == 4'h0);
            negative <= alu_result[3];
            overflow <= alu_overflow;
        end
    end

    // Hex digit patterns, bit0 = segment a through bit6 = segment g.
    always_comb begin
        segments = 7'h00;
        case (result)
            4'h0: segments = 7'h3F;
            4'h1: segments = 7'h06;
            4'h2: segments = 7'h5B;
            4'h3: segments = 7'h4F;
            4'h4: segments = 7'h66;
            4'h5: segments = 7'h6D;
            4'h6: segments = 7'h7D;
            4'h7: segments = 7'h07;
            4'h8: segments = 7'h7F;
            4'h9: segments = 7'h6F;
            4'hA: segments = 7'h77;
            4'hB: segments = 7'h7C;
            4'hC: segments = 7'h39;
            4'hD: segments = 7'h5E;
            4'hE: segments = 7'h79;
            4'hF: segments = 7'h71;
            default: segments = 7'h00;
        endcase
    end

    assign uo_out  = {carry, segments};
    assign uio_out = {overflow, negative, zero, carry, 4'h0};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_2bits_alu.sv
// Directed bench for tt_um_2bits_alu: a small reference model feeds a scoreboard queue
// that is popped and checked one clock after each stimulus step.
module tb_tt_um_2bits_alu;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    logic [15:0] exp_q[$];
    logic [15:0] model_state;

    tt_um_2bits_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int r);
        logic [6:0] table_v [16];
        table_v = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return table_v[r];
    endfunction

    // Returns {uo_out, uio_out} expected after one edge with these inputs.
    function automatic logic [15:0] model(input int a, input int b, input int op);
        int r, c, v, sa, sb, s;
        c = 0;
        v = 0;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        case (op)
            0: begin
                r = (a + b) % 16;
                c = (a + b > 15) ? 1 : 0;
                s = sa + sb;
                v = (s > 7 || s < -8) ? 1 : 0;
            end
            1: begin
                r = (a - b + 16) % 16;
                c = (a < b) ? 1 : 0;
                s = sa - sb;
                v = (s > 7 || s < -8) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin
                r = (a * 2) % 16;
                c = (a >= 8) ? 1 : 0;
            end
            default: begin
                r = a / 2;
                c = a % 2;
            end
        endcase
        return {c[0], seg_of(r), v[0], (r >= 8) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], 4'h0};
    endfunction

    task automatic check_output(input string tag);
        logic [15:0] exp_val;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            exp_val = exp_q.pop_front();
            assert (uo_out === exp_val[15:8]) else begin
                errors++;
                $error("FAIL %s uo_out got %h expected %h", tag, uo_out, exp_val[15:8]);
            end
            checks++;
            assert (uio_out === exp_val[7:0]) else begin
                errors++;
                $error("FAIL %s uio_out got %h expected %h", tag, uio_out, exp_val[7:0]);
            end
        end
        checks++;
        assert (uio_oe === 8'hF0) else begin
            errors++;
            $error("FAIL %s uio_oe got %h expected f0", tag, uio_oe);
        end
    endtask

    // Drives one step, updates the model, then checks just after the capturing edge.
    task automatic apply_stimulus(input string tag, input int a, input int b, input int op,
                                  input logic en, input logic rst);
        ui_in  = {b[3:0], a[3:0]};
        uio_in = {5'($urandom_range(0, 31)), op[2:0]};
        ena    = en;
        rst_n  = rst;
        if (rst)
            model_state = 16'h3F20;
        else if (en)
            model_state = model(a, b, op);
        exp_q.push_back(model_state);
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    // Absolute expectations straight from the worked examples.
    task automatic check_literal(input string tag, input logic [7:0] uo_exp, input logic [7:0] uio_exp);
        checks++;
        assert (uo_out === uo_exp && uio_out === uio_exp) else begin
            errors++;
            $error("FAIL %s got %h/%h expected %h/%h", tag, uo_out, uio_out, uo_exp, uio_exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_state = 16'h3F20;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        rst_n  = 1'b1;

        apply_stimulus("reset", 0, 0, 0, 1'b1, 1'b1);
        check_literal("reset_lit", 8'h3F, 8'h20);

        apply_stimulus("add_9_8", 9, 8, 0, 1'b1, 1'b0);
        check_literal("add_9_8_lit", 8'h86, 8'h90);
        apply_stimulus("sub_3_5", 3, 5, 1, 1'b1, 1'b0);
        check_literal("sub_3_5_lit", 8'hF9, 8'h50);
        apply_stimulus("and_c_a", 12, 10, 2, 1'b1, 1'b0);
        check_literal("and_c_a_lit", 8'h7F, 8'h40);
        apply_stimulus("xor_7_7", 7, 7, 4, 1'b1, 1'b0);
        check_literal("xor_7_7_lit", 8'h3F, 8'h20);
        apply_stimulus("shl_9", 9, 0, 6, 1'b1, 1'b0);
        check_literal("shl_9_lit", 8'hDB, 8'h10);
        apply_stimulus("shr_9", 9, 0, 7, 1'b1, 1'b0);
        check_literal("shr_9_lit", 8'hE6, 8'h10);
        apply_stimulus("or_5_a", 5, 10, 3, 1'b1, 1'b0);
        apply_stimulus("not_6", 6, 15, 5, 1'b1, 1'b0);
        apply_stimulus("sub_8_1_ovf", 8, 1, 1, 1'b1, 1'b0);
        apply_stimulus("add_7_1_ovf", 7, 1, 0, 1'b1, 1'b0);
        apply_stimulus("sub_equal", 6, 6, 1, 1'b1, 1'b0);

        apply_stimulus("hold_load", 2, 3, 0, 1'b1, 1'b0);
        check_literal("hold_load_lit", 8'h6D, 8'h00);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("hold", 15, 15, 1, 1'b0, 1'b0);
            check_literal("hold_lit", 8'h6D, 8'h00);
        end
        apply_stimulus("resume", 15, 15, 1, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++)
            apply_stimulus("sweep", i, 0, 0, 1'b1, 1'b0);

        apply_stimulus("pre_reset", 13, 9, 0, 1'b1, 1'b0);
        apply_stimulus("reset_no_ena", 13, 9, 0, 1'b0, 1'b1);
        check_literal("reset_no_ena_lit", 8'h3F, 8'h20);
        apply_stimulus("post_reset_idle", 4, 4, 0, 1'b0, 1'b0);
        apply_stimulus("post_reset_first", 4, 4, 0, 1'b1, 1'b0);

        for (int i = 0; i < 24; i++)
            apply_stimulus("random", $urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 7), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
